// File: rtl/gf_synd_seq.sv
// Reed-Solomon syndrome sequencer over GF(2^8) (poly 0x11D): Horner evaluation of NSYN syndromes
// through one time-shared multiplier. Optional error counter enabled by `define GF_SYND_ERRCNT_EN.
module gf_synd_seq #(
  parameter int NSYN   = 4,
  parameter int CW_LEN = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8*NSYN-1:0] out_synd,
  output logic              out_zero,
`ifdef GF_SYND_ERRCNT_EN
  output logic [15:0]       err_cnt,
`endif
  output logic              out_len_err
);

  // Handshakes: a transfer occurs on a rising edge where valid and ready are both high;
  // valid never depends combinationally on ready, and ready never on valid.
  typedef enum logic [1:0] {ACCEPT = 2'd0, UPDATE = 2'd1, DONE = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [7:0] synd_q [NSYN];
  logic [7:0] synd_d [NSYN];
  logic [3:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;
  logic [7:0] mul_a, mul_out;
  logic [15:0] ec_q, ec_d;

  function automatic logic [7:0] gf_mul_8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] alpha_pow(input logic [3:0] j);
    case (j)
      4'd0:  return 8'h01;
      4'd1:  return 8'h02;
      4'd2:  return 8'h04;
      4'd3:  return 8'h08;
      4'd4:  return 8'h10;
      4'd5:  return 8'h20;
      4'd6:  return 8'h40;
      4'd7:  return 8'h80;
      4'd8:  return 8'h1D;
      4'd9:  return 8'h3A;
      4'd10: return 8'h74;
      4'd11: return 8'hE8;
      4'd12: return 8'hCD;
      4'd13: return 8'h87;
      4'd14: return 8'h13;
      default: return 8'h26;
    endcase
  endfunction

  // Mux the accumulator selected by idx into the single shared multiplier.
  always_comb begin
    mul_a = 8'h00;
    for (int j = 0; j < NSYN; j++) begin
      if (idx_q == 4'(j)) mul_a = synd_q[j];
    end
    mul_out = gf_mul_8(mul_a, alpha_pow(idx_q)) ^ data_q;
  end

  always_comb begin
    out_synd = '0;
    for (int j = 0; j < NSYN; j++) out_synd[8*j +: 8] = synd_q[j];
  end

  assign in_ready    = (state_q == ACCEPT);
  assign out_valid   = (state_q == DONE);
  assign out_zero    = (out_synd == '0);
  assign out_len_err = out_valid && (cnt_q != 8'(CW_LEN));

  always_comb begin
    state_d = state_q;
    synd_d  = synd_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    last_d  = last_q;
    ec_d    = ec_q;
    case (state_q)
      ACCEPT: begin
        if (in_valid) begin
          data_d  = in_data;
          last_d  = in_last;
          cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          idx_d   = 4'd0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        for (int j = 0; j < NSYN; j++) begin
          if (idx_q == 4'(j)) synd_d[j] = mul_out;
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'(NSYN - 1)) state_d = last_q ? DONE : ACCEPT;
      end
      DONE: begin
        if (out_ready) begin
          for (int j = 0; j < NSYN; j++) synd_d[j] = 8'h00;
          cnt_d   = 8'd0;
          state_d = ACCEPT;
          if ((!out_zero || out_len_err) && ec_q != 16'hFFFF) ec_d = ec_q + 16'd1;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCEPT;
      for (int j = 0; j < NSYN; j++) synd_q[j] <= 8'h00;
      idx_q   <= 4'd0;
      cnt_q   <= 8'd0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      ec_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      synd_q  <= synd_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
      ec_q    <= ec_d;
    end
  end

`ifdef GF_SYND_ERRCNT_EN
  assign err_cnt = ec_q;
`else
  logic ec_unused;
  assign ec_unused = ^ec_q;
`endif

endmodule
